// File: rtl/cwt_scalogram_ctrl.sv
// rtl/cwt_scalogram_ctrl.sv - collects J scale rows of N samples into BRAM and streams the scalogram out; PINGPONG_EN selects two-bank overlap
module cwt_scalogram_ctrl #(
    parameter int N      = 1024,
    parameter int J      = 64,
    parameter int DW     = 32,
    parameter int RD_LAT = 2,
    localparam int NB    = $clog2(N),
    localparam int JB    = $clog2(J),
    localparam int FW    = NB + JB,
`ifdef PINGPONG_EN
    localparam int AW    = FW + 1
`else
    localparam int AW    = FW
`endif
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic [JB-1:0] out_scale,
    output logic          bram_we,
    output logic [AW-1:0] bram_waddr,
    output logic [DW-1:0] bram_wdata,
    output logic          bram_re,
    output logic [AW-1:0] bram_raddr,
    input  logic [DW-1:0] bram_rdata,
    output logic          busy_o,
    output logic          frame_done_o
);

    localparam int FD = RD_LAT + 2;
    localparam int PW = $clog2(FD);
    localparam int CW = $clog2(FD + 1) + 1;
    localparam int EW = DW + JB + 1;
`ifdef PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif
    localparam logic [NB-1:0] N_MAX = NB'(N - 1);
    localparam logic [JB-1:0] J_MAX = JB'(J - 1);
    localparam logic [FW-1:0] R_MAX = FW'(N * J - 1);

    typedef enum logic {W_FILL, W_HOLD} wstate_t;
    typedef enum logic {R_IDLE, R_DRAIN} rstate_t;

    wstate_t         r_wstate, w_wstate_nx;
    rstate_t         r_rstate, w_rstate_nx;
    logic            r_run;
    logic [NB-1:0]   r_n;
    logic [JB-1:0]   r_j;
    logic [FW-1:0]   r_r;
    logic            r_iss_done;
    logic [RD_LAT-1:0] r_vpipe;
    logic [JB:0]     r_spipe [RD_LAT];
    logic [CW-1:0]   r_outst;
    logic [CW-1:0]   r_fcnt;
    logic [PW-1:0]   r_wp, r_rp;
    logic [EW-1:0]   r_fmem [FD];
`ifdef PINGPONG_EN
    logic            r_wb, r_rb;
`endif

    logic            w_in_ready, w_wr, w_frame_wr, w_rd_free, w_handoff;
    logic            w_issue, w_push, w_pop, w_rd_done;
    logic [EW-1:0]   w_head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_wr       = in_valid && w_in_ready;
    assign w_frame_wr = w_wr && (r_n == N_MAX) && (r_j == J_MAX);
    assign w_head     = r_fmem[r_rp];
    assign w_pop      = (r_fcnt != '0) && out_ready;
    assign w_rd_done  = w_pop && w_head[EW-1];
    assign w_rd_free  = (r_rstate == R_IDLE) || w_rd_done;
    assign w_push     = r_vpipe[RD_LAT-1];

    // Writer FSM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wstate <= W_FILL;
        end else begin
            r_wstate <= w_wstate_nx;
        end
    end

    always_comb begin
        w_wstate_nx = r_wstate;
        case (r_wstate)
            W_FILL:  if (w_frame_wr && !(PP && w_rd_free)) w_wstate_nx = W_HOLD;
            W_HOLD:  if (w_rd_free) w_wstate_nx = W_FILL;
            default: w_wstate_nx = W_FILL;
        endcase
    end

    // Single bank: the frame goes to the reader as soon as it is complete and
    // the writer waits out the drain; two banks: handoff waits for a free reader.
    always_comb begin
        w_in_ready = r_run && (r_wstate == W_FILL);
        w_handoff  = 1'b0;
        case (r_wstate)
            W_FILL:  w_handoff = w_frame_wr && (!PP || w_rd_free);
            W_HOLD:  w_handoff = PP && w_rd_free;
            default: w_handoff = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_run <= 1'b0;
            r_n   <= '0;
            r_j   <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_wr) begin
                if (r_n == N_MAX) begin
                    r_n <= '0;
                    r_j <= (r_j == J_MAX) ? '0 : r_j + 1'b1;
                end else begin
                    r_n <= r_n + 1'b1;
                end
            end
        end
    end

`ifdef PINGPONG_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wb <= 1'b0;
            r_rb <= 1'b0;
        end else if (w_handoff) begin
            r_wb <= ~r_wb;
            r_rb <= r_wb;
        end
    end
`endif

    // Reader FSM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_nx;
        end
    end

    always_comb begin
        w_rstate_nx = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_handoff) w_rstate_nx = R_DRAIN;
            R_DRAIN: if (w_rd_done && !w_handoff) w_rstate_nx = R_IDLE;
            default: w_rstate_nx = R_IDLE;
        endcase
    end

    // Credit check counts reads in flight plus buffered words, so the skid
    // FIFO can never overflow whatever out_ready does.
    always_comb begin
        w_issue = (r_rstate == R_DRAIN) && !r_iss_done &&
                  ((r_outst + r_fcnt) < CW'(FD));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_r        <= '0;
            r_iss_done <= 1'b0;
        end else if (w_handoff) begin
            r_r        <= '0;
            r_iss_done <= 1'b0;
        end else if (w_issue) begin
            if (r_r == R_MAX) r_iss_done <= 1'b1;
            else              r_r        <= r_r + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vpipe <= '0;
            for (int k = 0; k < RD_LAT; k++) r_spipe[k] <= '0;
        end else begin
            r_vpipe[0] <= w_issue;
            r_spipe[0] <= {r_r == R_MAX, r_r[FW-1:NB]};
            for (int k = 1; k < RD_LAT; k++) begin
                r_vpipe[k] <= r_vpipe[k-1];
                r_spipe[k] <= r_spipe[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_outst <= '0;
            r_fcnt  <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
        end else begin
            case ({w_issue, w_push})
                2'b10:   r_outst <= r_outst + 1'b1;
                2'b01:   r_outst <= r_outst - 1'b1;
                default: r_outst <= r_outst;
            endcase
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + 1'b1;
                2'b01:   r_fcnt <= r_fcnt - 1'b1;
                default: r_fcnt <= r_fcnt;
            endcase
            if (w_push) r_wp <= ptr_inc(r_wp);
            if (w_pop)  r_rp <= ptr_inc(r_rp);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fmem[r_wp] <= {r_spipe[RD_LAT-1], bram_rdata};
    end

    assign in_ready     = w_in_ready;
    assign bram_we      = w_wr;
    assign bram_wdata   = w_wr ? in_data : '0;
    assign bram_re      = w_issue;
`ifdef PINGPONG_EN
    assign bram_waddr   = {r_wb, r_j, r_n};
    assign bram_raddr   = {r_rb, r_r};
`else
    assign bram_waddr   = {r_j, r_n};
    assign bram_raddr   = r_r;
`endif
    assign out_valid    = (r_fcnt != '0);
    assign out_data     = out_valid ? w_head[DW-1:0] : '0;
    assign out_scale    = out_valid ? w_head[DW+JB-1:DW] : '0;
    assign out_last     = out_valid && w_head[EW-1];
    assign frame_done_o = w_rd_done;
    assign busy_o       = (r_n != '0) || (r_j != '0) || (r_wstate == W_HOLD) ||
                          (r_rstate == R_DRAIN);

endmodule

// File: tb/tb_cwt_scalogram_ctrl.sv
// tb/tb_cwt_scalogram_ctrl.sv - directed/random bench for cwt_scalogram_ctrl against a frame-level model
module tb_cwt_scalogram_ctrl;

    localparam int N = 8, J = 4, DW = 16, RD_LAT = 2;
    localparam int FD = RD_LAT + 2, NJ = N * J, JB = 2;
`ifdef PINGPONG_EN
    localparam int AW = 6;
    localparam bit PP = 1'b1;
`else
    localparam int AW = 5;
    localparam bit PP = 1'b0;
`endif

    logic clk = 1'b0, rstn = 1'b0;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_last;
    logic [DW-1:0] in_data = '0, out_data, bram_wdata, bram_rdata;
    logic [JB-1:0] out_scale;
    logic bram_we, bram_re, busy_o, frame_done_o;
    logic [AW-1:0] bram_waddr, bram_raddr;

    always #5 clk = ~clk;

    cwt_scalogram_ctrl #(.N(N), .J(J), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .out_scale(out_scale), .bram_we(bram_we), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata),
        .bram_re(bram_re), .bram_raddr(bram_raddr), .bram_rdata(bram_rdata), .busy_o(busy_o),
        .frame_done_o(frame_done_o)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rpipe [0:RD_LAT-1];
    always @(posedge clk) begin
        if (bram_we) mem[bram_waddr] <= bram_wdata;
        rpipe[0] <= bram_re ? mem[bram_raddr] : DW'($urandom);
        for (int k = 1; k < RD_LAT; k++) rpipe[k] <= rpipe[k-1];
    end
    assign bram_rdata = rpipe[RD_LAT-1];

    int n_assert = 0, n_fail = 0;
    logic [DW-1:0] src[$], part[$], expq[$];
    bit run = 0, m_hold = 0, m_rd_busy = 0, sync_last = 0, prev_stall = 0;
    int part_cnt = 0, hcnt = 0, rd_idx = 0, issued = 0, accepted = 0, out_idx = 0;
    int mode = 0, cyc = 0, t0 = 0, n_done = 0, n_blocked = 0, n_stall = 0;
    int first_hs = 0, last_hs = 0;
    logic [DW-1:0] prev_data;
    logic [JB:0]   prev_side;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int base, input bit rnd);
        for (int i = 0; i < NJ; i++) src.push_back(rnd ? DW'($urandom) : DW'(base + i));
    endtask

    task automatic tick();
        bit acc, hs, done_exp, free, handoff, hold_nx, busy_nx;
        logic [AW-1:0] ea;
        @(negedge clk);
        cyc++;
        case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = !(cyc >= t0 && cyc < t0 + 20);
        endcase
        #1;
        if (src.size() > 0 && !(sync_last && src.size() == 1 && m_rd_busy && frame_done_o !== 1'b1)) begin
            in_valid = 1'b1;
            in_data  = src[0];
        end else begin
            in_valid = 1'b0;
            in_data  = DW'($urandom);
        end
        #1;
        acc = in_valid && run && !m_hold;
        chk("in_ready", in_ready, run && !m_hold);
        chk("bram_we", bram_we, acc);
        if (in_valid && !in_ready) n_blocked++;
        if (acc) begin
            ea = AW'(part_cnt);
            if (PP && hcnt % 2 == 1) ea[AW-1] = 1'b1;
            chk("bram_waddr", bram_waddr, ea);
            chk("bram_wdata", bram_wdata, in_data);
            void'(src.pop_front());
            part.push_back(in_data);
            part_cnt++;
        end
        hs = out_valid && out_ready;
        if (out_valid && !out_ready) n_stall++;
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, prev_data);
            chk("stall_side", {out_last, out_scale}, prev_side);
        end
        if (out_valid === 1'b1) begin
            if (expq.size() == 0) chk("spurious_valid", 1, 0);
            else begin
                chk("out_data", out_data, expq[0]);
                chk("out_scale", out_scale, out_idx / N);
                chk("out_last", out_last, out_idx == NJ - 1);
            end
        end
        done_exp = hs && expq.size() > 0 && out_idx == NJ - 1;
        chk("frame_done", frame_done_o, done_exp);
        if (frame_done_o === 1'b1) n_done++;
        if (bram_re === 1'b1) begin
            ea = AW'(rd_idx);
            if (PP && (hcnt - 1) % 2 == 1) ea[AW-1] = 1'b1;
            chk("bram_raddr", bram_raddr, ea);
            chk("read_in_drain", m_rd_busy && rd_idx < NJ, 1);
            rd_idx++;
            issued++;
            chk("fd_bound", (issued - accepted) <= FD, 1);
        end
        if (hs && expq.size() > 0) begin
            void'(expq.pop_front());
            accepted++;
            if (out_idx == 0) first_hs = cyc;
            last_hs = cyc;
            out_idx = (out_idx == NJ - 1) ? 0 : out_idx + 1;
        end
        free = !m_rd_busy || done_exp;
        handoff = 0;
        hold_nx = m_hold;
        if (acc && part_cnt == NJ) begin
            foreach (part[i]) expq.push_back(part[i]);
            part.delete();
            part_cnt = 0;
            if (!PP || free) handoff = 1;
            if (!PP || !free) hold_nx = 1;
        end else if (m_hold && free) begin
            hold_nx = 0;
            if (PP) handoff = 1;
        end
        busy_nx = handoff ? 1'b1 : (done_exp ? 1'b0 : m_rd_busy);
        if (handoff) begin
            hcnt++;
            rd_idx = 0;
        end
        m_hold = hold_nx;
        m_rd_busy = busy_nx;
        prev_stall = out_valid && !out_ready;
        prev_data = out_data;
        prev_side = {out_last, out_scale};
    endtask

    task automatic do_reset(input int cycles);
        rstn = 1'b0;
        run = 0; m_hold = 0; m_rd_busy = 0; prev_stall = 0;
        src.delete(); part.delete(); expq.delete();
        part_cnt = 0; hcnt = 0; rd_idx = 0; issued = 0; accepted = 0; out_idx = 0;
        mode = 0;
        repeat (cycles) begin
            tick();
            chk("reset_zero", {in_ready, out_valid, out_data, out_last, out_scale, bram_we, bram_waddr,
                               bram_wdata, bram_re, bram_raddr, busy_o, frame_done_o}, 0);
        end
        rstn = 1'b1;
        run = 1;
    endtask

    task automatic run_idle(input string tag);
        int k = 0;
        while ((src.size() > 0 || expq.size() > 0 || part_cnt > 0 || m_hold || m_rd_busy) && k < 600) begin
            tick();
            k++;
        end
        chk({tag, "_timeout"}, k < 600, 1);
        tick();
        chk({tag, "_busy_idle"}, busy_o, 0);
    endtask

    initial begin
        do_reset(3);

        n_done = 0; mode = 0;
        load(0, 0);
        run_idle("t1");
        chk("t1_done_cnt", n_done, 1);
        chk("t1_throughput", last_hs - first_hs, NJ - 1);

        n_done = 0; mode = 1;
        load(64, 0);
        run_idle("t2a");
        mode = 2;
        load(0, 1);
        run_idle("t2b");
        chk("t2_done_cnt", n_done, 2);

        n_done = 0; n_blocked = 0; mode = 0;
        load(1000, 0);
        load(100, 0);
        run_idle("t3");
        chk("t3_done_cnt", n_done, 2);
        chk("t3_collect_blocked", n_blocked >= NJ, PP ? 0 : 1);

        n_done = 0; n_blocked = 0; sync_last = 1;
        load(300, 0);
        load(400, 0);
        run_idle("t4");
        sync_last = 0;
        chk("t4_done_cnt", n_done, 2);
        chk("t4_no_bubble", n_blocked == 0, PP ? 1 : 0);

        n_done = 0;
        load(500, 0);
        begin
            int k = 0;
            while (part_cnt < 13 && k < 100) begin tick(); k++; end
            chk("t5_partial_timeout", k < 100, 1);
        end
        do_reset(3);
        load(200, 0);
        run_idle("t5");
        chk("t5_done_cnt", n_done, 1);

        n_done = 0; n_stall = 0; mode = 3; t0 = cyc + 45;
        load(0, 1);
        run_idle("t6");
        chk("t6_done_cnt", n_done, 1);
        chk("t6_stalled", n_stall >= 15, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
